load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Illegal width code for the direction, or an access not naturally aligned.
  function automatic logic lsu_is_bad(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication and byte enables, load extraction and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    wdata_o = wdata_i;
    be_o    = BE_W;
    case (funct3_i)
      F3_B: begin
        wdata_o = {4{wdata_i[7:0]}};
        be_o    = BE_B << addr_lo_i;
      end
      F3_H: begin
        wdata_o = {2{wdata_i[15:0]}};
        be_o    = BE_H << addr_lo_i;
      end
      default: ;
    endcase
    if (!we_i) be_o = 4'b0000;
  end

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    rdata_o = rdata_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_o = {24'b0, shifted[7:0]};
      F3_HU:   rdata_o = {16'b0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, request/response handshake to data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state_q;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CntW-1:0] cnt_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic [31:0]   load_data;

  lsu_align u_align (
    .we_i      (we_q),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_resp_rdata),
    .wdata_o   (mem_wdata),
    .be_o      (mem_be),
    .rdata_o   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_rdata_q <= 32'b0;
            // Bad requests skip the memory entirely and report straight away.
            if (lsu_is_bad(req_we, req_funct3, req_addr[1:0])) begin
              state_q    <= RESP;
              resp_err_q <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              resp_err_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state_q <= WAIT;
            cnt_q   <= '0;
          end
        end
        WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (mem_resp_valid) begin
            state_q      <= RESP;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'b0 : load_data;
          end else if (cnt_q == CntLast) begin
            state_q      <= RESP;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE) && !rst;
  assign busy          = (state_q != IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q[31:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a response scoreboard.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        busy;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && resp_valid === 1'b1) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_resp: observed err=%b rdata=%h expected none",
               resp_err, resp_rdata);
      end
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        assert ({resp_err, resp_rdata} === {e.err, e.rdata}) else begin
          failures++;
          $error("FAIL resp: observed err=%b rdata=%h expected err=%b rdata=%h",
                 resp_err, resp_rdata, e.err, e.rdata);
        end
      end
    end
  end

  task automatic reset_outputs_chk(input string tag);
    chk({tag, " req_ready"},     32'(req_ready),     32'd0);
    chk({tag, " resp_valid"},    32'(resp_valid),    32'd0);
    chk({tag, " resp_rdata"},    resp_rdata,         32'd0);
    chk({tag, " resp_err"},      32'(resp_err),      32'd0);
    chk({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, " mem_we"},        32'(mem_we),        32'd0);
    chk({tag, " mem_be"},        32'(mem_be),        32'd0);
    chk({tag, " mem_addr"},      32'(mem_addr),      32'd0);
    chk({tag, " mem_wdata"},     mem_wdata,          32'd0);
    chk({tag, " busy"},          32'(busy),          32'd0);
  endtask

  // rdy_dly: ISSUE cycles with mem_req_ready low; rsp_dly: WAIT cycles before the
  // response (negative = never). Latency counts clock edges from the accept edge.
  task automatic do_acc(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] mrdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    int issue_n;
    int wait_n;
    int lat;
    issue_n = 0;
    wait_n  = 0;
    lat     = 0;
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid      = 1'b1;
    req_we         = we;
    req_funct3     = f3;
    req_addr       = addr;
    req_wdata      = wdata;
    mem_resp_rdata = mrdata;
    sb_q.push_back('{err: exp_err, rdata: exp_rdata});
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      req_valid      = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (mem_req_valid) begin
        chk({tag, " mem_addr"},  32'(mem_addr), addr >> 2);
        chk({tag, " mem_be"},    32'(mem_be), 32'(exp_be));
        chk({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        chk({tag, " mem_we"},    32'(mem_we), 32'(we));
        if (issue_n == rdy_dly) mem_req_ready = 1'b1;
        issue_n++;
      end else if (busy && issue_n > 0) begin
        if (wait_n == rsp_dly) mem_resp_valid = 1'b1;
        wait_n++;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " issue_cycles"}, 32'(issue_n), (exp_lat == 1) ? 32'd0 : 32'(rdy_dly + 1));
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_funct3     = 3'b000;
    req_addr       = 32'b0;
    req_wdata      = 32'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'b0;

    repeat (2) @(negedge clk);
    reset_outputs_chk("por");
    rst = 1'b0;
    #1;
    chk("por req_ready_after", 32'(req_ready), 32'd1);

    //     tag        we    f3      addr          wdata         rdy rsp mrdata
    //                be       mem_wdata     err   rdata         lat
    do_acc("sw",      1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,
           4'b1111, 32'hDEADBEEF, 1'b0, 32'h0,        3);
    do_acc("lb",      1'b0, 3'b000, 32'h103, 32'h0,        0, 0, 32'h80FF00AA,
           4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 3);
    do_acc("lbu",     1'b0, 3'b100, 32'h103, 32'h0,        0, 0, 32'h80FF00AA,
           4'b0000, 32'h0,        1'b0, 32'h00000080, 3);
    do_acc("lhu",     1'b0, 3'b101, 32'h102, 32'h0,        0, 0, 32'h80FF00AA,
           4'b0000, 32'h0,        1'b0, 32'h000080FF, 3);
    do_acc("lh",      1'b0, 3'b001, 32'h102, 32'h0,        0, 2, 32'h80FF00AA,
           4'b0000, 32'h0,        1'b0, 32'hFFFF80FF, 5);
    do_acc("sh",      1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'h0,
           4'b1100, 32'hABCDABCD, 1'b0, 32'h0,        3);
    do_acc("lw_mis",  1'b0, 3'b010, 32'h101, 32'h0,        0, 0, 32'h0,
           4'b0000, 32'h0,        1'b1, 32'h0,        1);
    do_acc("sb_stall", 1'b1, 3'b000, 32'h101, 32'h00000055, 5, 0, 32'h0,
           4'b0010, 32'h55555555, 1'b0, 32'h0,        8);
    do_acc("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0,      0, 0, 32'h0,
           4'b0000, 32'h0,        1'b1, 32'h0,        1);
    do_acc("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h0,      0, 0, 32'h0,
           4'b0000, 32'h0,        1'b1, 32'h0,        1);
    do_acc("sh_mis",  1'b1, 3'b001, 32'h103, 32'h0,        0, 0, 32'h0,
           4'b0000, 32'h0,        1'b1, 32'h0,        1);
    do_acc("lw",      1'b0, 3'b010, 32'h204, 32'h0,        0, 0, 32'h12345678,
           4'b0000, 32'h0,        1'b0, 32'h12345678, 3);
    do_acc("timeout", 1'b0, 3'b010, 32'h200, 32'h0,        0, -1, 32'hDEADBEEF,
           4'b0000, 32'h0,        1'b1, 32'h0,        18);
    do_acc("tie",     1'b0, 3'b010, 32'h200, 32'h0,        0, 15, 32'hCAFEF00D,
           4'b0000, 32'h0,        1'b0, 32'hCAFEF00D, 18);

    // Reset while waiting on memory, then a stale response right after.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    @(negedge clk);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rst_wait busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    reset_outputs_chk("rst_wait");
    rst = 1'b0;
    #1;
    chk("rst_wait req_ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_wait no_resp", 32'(resp_valid), 32'd0);
      chk("rst_wait idle", 32'(busy), 32'd0);
      @(negedge clk);
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
